periph_bus_master: RTL and testbench
====================================

PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 16, read-wait cycles before timeout error (range 1-255).
REQ-002 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have req_valid  input  1, req_ready  output  1: CPU-side request handshake.
REQ-005 SHALL have req_we  input  1, 1=store 0=load.
REQ-006 SHALL have req_size  input  2: 0 byte, 1 half, 2 word, 3 reserved.
REQ-007 SHALL have req_unsigned  input  1, load zero-extend when 1, sign-extend when 0.
REQ-008 SHALL have req_addr  input  16 byte address, and req_wdata  input  32 store data (LSB-aligned).
REQ-009 SHALL have resp_valid  output  1 one-cycle pulse, resp_rdata  output  32, resp_err  output  1.
REQ-010 SHALL have bus-side wr_en  output  1, be  output  4, wr_addr  output  16, wdata  output  32.
REQ-011 SHALL have bus-side rd_en  output  1, rd_addr  output  16, rdata  input  32, rd_rdy  input  1.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD, RWAIT, RESP; req_ready=1 only in IDLE.
REQ-013 SHALL accept a request when req_valid & req_ready at edge N; request fields captured at that edge.
REQ-014 SHALL flag misaligned: half with addr[0]=1, word with addr[1:0]!=0, size 3; IDLE->RESP, no bus strobe, resp_err=1, resp_rdata=0.
REQ-015 SHALL, for aligned store: IDLE->WR; in WR (cycle N+1) wr_en=1 one cycle, resp_valid=1, resp_err=0; WR->IDLE.
REQ-016 SHALL drive wr_addr/rd_addr = {req_addr[15:2],2'b00}.
REQ-017 SHALL drive be: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111.
REQ-018 SHALL replicate store data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
REQ-019 SHALL, for aligned load: IDLE->RD; in RD (N+1) rd_en=1 one cycle; RD->RWAIT.
REQ-020 SHALL, in RWAIT with rd_rdy=1, capture rdata, shift right by 8*addr[1:0], mask to size, extend per req_unsigned; ->RESP.
REQ-021 SHALL assert resp_valid for one cycle in RESP (load minimum: N+3), then RESP->IDLE.
REQ-022 SHALL drive wr_en, rd_en, be, wr_addr, rd_addr, wdata to 0 outside their strobe cycle.
REQ-023 SHALL hold resp_rdata/resp_err valid only while resp_valid=1, 0 otherwise.
REQ-024 SHALL ignore rd_rdy in any state but RWAIT.
REQ-025 SHALL ignore req_valid when req_ready=0; next request accepted earliest cycle after resp_valid.

Reset
REQ-026 SHALL, with rst=1 at an edge, enter IDLE and clear all outputs and timeout counter to 0 (req_ready reads 1 from first cycle after reset).
REQ-027 SHALL abort any in-flight transaction on rst without resp_valid; late rd_rdy afterwards ignored.

Configuration
REQ-028 SHALL, with PERIPH_BUS_TIMEOUT_EN defined, count RWAIT cycles; on reaching TIMEOUT_CYCLES without rd_rdy go to RESP with resp_err=1, resp_rdata=0; rd_rdy on the final cycle wins (normal data).
REQ-029 SHALL, without PERIPH_BUS_TIMEOUT_EN, omit the counter and wait in RWAIT indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-030 SHALL test store byte addr 0x0005 wdata 0x000000AB -> N+1 wr_en=1, wr_addr 0x0004, be 4'b0010, wdata 0xABABABAB, resp_valid=1 err=0.
REQ-031 SHALL test load half signed addr 0x0002, rd_rdy next cycle rdata 0x8001_1234 -> rd_en N+1, rd_addr 0x0000, resp_valid N+3 resp_rdata 0xFFFF8001; unsigned -> 0x00008001.
REQ-032 SHALL test load word addr 0x0006 -> no rd_en/wr_en, resp_valid N+1, resp_err=1, resp_rdata 0.
REQ-033 SHALL test with PERIPH_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, rd_rdy held 0 -> resp_valid err=1 after 4 RWAIT cycles; rd_rdy on 4th cycle -> data, err=0.
REQ-034 SHALL test rst=1 in RWAIT then rd_rdy=1 -> no resp_valid, IDLE, req_ready=1 next cycle.
REQ-035 SHALL test back-to-back store then load word addr 0x0004 -> second accepted cycle after first resp_valid, be 4'b1111.

Source files
------------

// File: rtl/periph_bus_master.sv
// periph_bus_master
//   Bridges a CPU-style load/store request into single-beat strobes on a
//   simple peripheral bus. It does one transaction at a time.
//   The request is accepted only in IDLE. Stores complete in the strobe
//   cycle. Loads wait in RWAIT for rd_rdy, then return data in RESP.
//   Misaligned accesses and the reserved size never touch the bus. They
//   return an error response one cycle after acceptance.
//
// Ports
//   clk, rst            sole clock (rising edge); synchronous active-high reset
//   req_*               request: valid/ready, we, size, unsigned, addr, wdata
//   resp_*              one-cycle response pulse with rdata/err
//   wr_en/be/wr_addr/wdata   store strobe (word address, lane-replicated data)
//   rd_en/rd_addr/rdata/rd_rdy  load strobe and read-return handshake
//
// Configuration
//   PERIPH_BUS_TIMEOUT_EN  when defined, RWAIT is bounded by TIMEOUT_CYCLES.
//                          A timeout returns resp_err=1. Without it, RWAIT
//                          waits indefinitely.
module periph_bus_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        wr_en,
  output logic [3:0]  be,
  output logic [15:0] wr_addr,
  output logic [31:0] wdata,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [31:0] rdata,
  input  logic        rd_rdy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("periph_bus_master: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_t;

  state_t      state, state_d;
  logic [15:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        misaligned;
  logic        tmo;
  logic [31:0] shifted;
  logic [31:0] ld_val;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Bring the addressed byte lane down to bit 0, then trim to the access size
  // and extend.
  always_comb begin
    shifted = rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    ld_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

`ifdef PERIPH_BUS_TIMEOUT_EN
  // tcnt holds the number of RWAIT cycles already spent without rd_rdy.
  logic [7:0] tcnt;
  assign tmo = (tcnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                               tcnt <= '0;
    else if (state != RWAIT)               tcnt <= '0;
    else if (!rd_rdy)                      tcnt <= tcnt + 8'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = misaligned ? RESP : (req_we ? WR : RD);
      WR:      state_d = IDLE;
      RD:      state_d = RWAIT;
      RWAIT:   if (rd_rdy || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= misaligned;
      end else if (state == RWAIT) begin
        // rd_rdy takes priority over a timeout on the same cycle.
        if (rd_rdy) begin
          rdata_q <= ld_val;
          err_q   <= 1'b0;
        end else if (tmo) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Outputs stay zero outside their strobe and response cycles.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    wr_en      = 1'b0;
    be         = '0;
    wr_addr    = '0;
    wdata      = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      WR: begin
        wr_en      = 1'b1;
        wr_addr    = {addr_q[15:2], 2'b00};
        resp_valid = 1'b1;
        case (size_q)
          2'd0: begin
            be    = 4'b0001 << addr_q[1:0];
            wdata = {4{wdata_q[7:0]}};
          end
          2'd1: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            be    = 4'b1111;
            wdata = wdata_q;
          end
        endcase
      end
      RD: begin
        rd_en   = 1'b1;
        rd_addr = {addr_q[15:2], 2'b00};
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_periph_bus_master.sv
module tb_periph_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        wr_en, rd_en, rd_rdy;
  logic [3:0]  be;
  logic [15:0] wr_addr, rd_addr;
  logic [31:0] wdata, rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  periph_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .wr_en(wr_en), .be(be), .wr_addr(wr_addr),
    .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata),
    .rd_rdy(rd_rdy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Reference model, written from the access rules with plain arithmetic.
  function automatic bit m_err(input int size, input int addr);
    return size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] m_be(input int size, input int addr);
    int nb = 1 << size;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wd(input int size, input longint w);
    if (size == 0) return 32'((w % 256) * 32'h01010101);
    if (size == 1) return 32'((w % 65536) * 65537);
    return 32'(w);
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns, input int addr,
                                          input longint rd);
    int     bits = 8 * (1 << size);
    longint lim = longint'(1) << bits;
    longint v = (rd / (longint'(1) << (8 * (addr % 4)))) % lim;
    if (!uns && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // Runs one transaction from request to response. It is entered and left
  // 1ns after a rising edge.
  task automatic run_txn(input string nm, input bit we, input logic [1:0] size,
                         input bit uns, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly,
                         input bit e_err, input logic [31:0] e_rdata,
                         input logic [3:0] e_be, input logic [31:0] e_wd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk); chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    if (e_err) begin
      chk({nm, ".err_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, ".err"},       32'(resp_err), 32'd1);
      chk({nm, ".err_rdata"}, resp_rdata, 32'd0);
      chk({nm, ".no_strobe"}, 32'({wr_en, rd_en}), 32'd0);
      @(posedge clk); #1;
    end else if (we) begin
      chk({nm, ".wr_en"},   32'(wr_en), 32'd1);
      chk({nm, ".wr_addr"}, 32'(wr_addr), 32'(addr & 16'hFFFC));
      chk({nm, ".be"},      32'(be), 32'(e_be));
      chk({nm, ".wdata"},   wdata, e_wd);
      chk({nm, ".resp"},    32'({resp_valid, resp_err, req_ready}), 32'b100);
      @(posedge clk); #1;
    end else begin
      chk({nm, ".rd_en"},   32'(rd_en), 32'd1);
      chk({nm, ".rd_addr"}, 32'(rd_addr), 32'(addr & 16'hFFFC));
      chk({nm, ".rd_noresp"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < dly; i++) begin
        // A request raised while busy must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 16'h0;
        @(negedge clk);
        chk({nm, ".wait"}, 32'({resp_valid, req_ready, wr_en, rd_en, be}), 32'd0);
        @(posedge clk); #1;
      end
      req_valid = 1'b0; rd_rdy = 1'b1; rdata = rd;
      @(posedge clk); #1; rd_rdy = 1'b0; rdata = $urandom;
      @(negedge clk);
      chk({nm, ".valid"}, 32'(resp_valid), 32'd1);
      chk({nm, ".err0"},  32'(resp_err), 32'd0);
      chk({nm, ".rdata"}, resp_rdata, e_rdata);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       nm;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    bit          e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"st_byte5",  1, 0, 0, 16'h0005, 32'h000000AB, 0, 0, 0, 0, 4'b0010, 32'hABABABAB};
    vecs[1]  = '{"ld_half_s", 0, 1, 0, 16'h0002, 0, 32'h80011234, 0, 0, 32'hFFFF8001, 0, 0};
    vecs[2]  = '{"ld_half_u", 0, 1, 1, 16'h0002, 0, 32'h80011234, 0, 0, 32'h00008001, 0, 0};
    vecs[3]  = '{"ld_mis_w",  0, 2, 0, 16'h0006, 0, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{"st_word4",  1, 2, 0, 16'h0004, 32'h12345678, 0, 0, 0, 0, 4'b1111, 32'h12345678};
    vecs[5]  = '{"ld_word4",  0, 2, 0, 16'h0004, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0};
    vecs[6]  = '{"ld_byte_s", 0, 0, 0, 16'h0013, 0, 32'h80000000, 2, 0, 32'hFFFFFF80, 0, 0};
    vecs[7]  = '{"st_half_hi",1, 1, 0, 16'h000A, 32'hFFFFBEEF, 0, 0, 0, 0, 4'b1100, 32'hBEEFBEEF};
    vecs[8]  = '{"st_mis_h",  1, 1, 0, 16'h0003, 32'h1, 0, 0, 1, 0, 0, 0};
    vecs[9]  = '{"ld_size3",  0, 3, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{"ld_byte_u", 0, 0, 1, 16'h0001, 0, 32'h0000F100, 1, 0, 32'h000000F1, 0, 0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rdata = '0; rd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.outs", 32'({resp_valid, resp_err, wr_en, rd_en, be}), 32'd0);
    chk("reset.bus", {wr_addr, rd_addr} | wdata | resp_rdata, 32'd0);

    // rd_rdy in IDLE must not produce anything.
    @(posedge clk); #1 rd_rdy = 1'b1;
    @(negedge clk); chk("idle_rdy", 32'({resp_valid, rd_en}), 32'd0);
    @(posedge clk); #1 rd_rdy = 1'b0;

    // Vectors 4 and 5 run back to back: the load is accepted on the edge
    // right after the store's response cycle.
    foreach (vecs[i])
      run_txn(vecs[i].nm, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
              vecs[i].wd, vecs[i].rd, vecs[i].dly, vecs[i].e_err, vecs[i].e_rdata,
              vecs[i].e_be, vecs[i].e_wd);

    // Reset while in RWAIT aborts the load. A late rd_rdy is then ignored.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 16'h0040;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; rd_rdy = 1'b1; rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rst_rwait.noresp", 32'(resp_valid), 32'd0);
    chk("rst_rwait.ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rd_rdy = 1'b0;
    @(negedge clk); chk("rst_rwait.late", 32'({resp_valid, rd_en}), 32'd0);
    @(posedge clk); #1;

`ifdef PERIPH_BUS_TIMEOUT_EN
    // rd_rdy held low for 4 RWAIT cycles causes a timeout error.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 16'h0020;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("tmo.wait", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo.valid", 32'(resp_valid), 32'd1);
    chk("tmo.err", 32'(resp_err), 32'd1);
    chk("tmo.rdata", resp_rdata, 32'd0);
    @(posedge clk); #1 rd_rdy = 1'b1;
    @(negedge clk); chk("tmo.late_rdy", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 rd_rdy = 1'b0;
    // rd_rdy on the 4th RWAIT cycle still returns data.
    run_txn("tmo.last_cycle", 0, 2, 0, 16'h0024, 0, 32'hCAFEF00D, 3, 0, 32'hCAFEF00D, 0, 0);
`endif

    // Randomized transactions checked against the reference model.
    for (int n = 0; n < 80; n++) begin
      bit          we  = 1'($urandom);
      logic [1:0]  sz  = 2'($urandom);
      bit          un  = 1'($urandom);
      logic [15:0] ad  = 16'($urandom);
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      int          dly = $urandom_range(0, 3);
      run_txn("rand", we, sz, un, ad, wd, rd, dly, m_err(int'(sz), int'(ad)),
              m_load(int'(sz), un, int'(ad), longint'(rd)),
              m_be(int'(sz), int'(ad)), m_wd(int'(sz), longint'(wd)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
